hilo_div_unit: RTL

Sequential divider and HI/LO register file that sits directly downstream of the arithmetic/shift/multiply cluster. It captures the 64-bit product from the multiplier when the multiplier signals completion. It runs DIV/DIVU as a 32-iteration restoring divider, and holds HI/LO for MFHI/MFLO. The control unit stalls on `busy` and reads `HI`/`LO` directly.

---
 rtl/hilo_div_unit.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/hilo_div_unit.sv
// HI/LO register file with multiplier-product capture, MTHI/MTLO writes and an
// optional 32-iteration restoring divider enabled by the HILO_DIV_EN macro.
module hilo_div_unit (
   input  logic        Clk,
   input  logic        reset,
   input  logic [31:0] oper_A,
   input  logic [31:0] oper_B,
   input  logic        startDiv,
   input  logic        divSigned,
   input  logic [63:0] mul,
   input  logic        endMult,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] wdata,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        busy,
   output logic        endDiv,
   output logic        divByZero
);

   logic [31:0] hi_q, hi_d, lo_q, lo_d;

   assign HI = hi_q;
   assign LO = lo_q;

`ifdef HILO_DIV_EN

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_ZERO} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] rem_q, rem_d, quot_q, quot_d, dvsr_q, dvsr_d;
   logic        negq_q, negq_d, negr_q, negr_d;
   logic        end_q, end_d, dbz_q, dbz_d;
   logic [33:0] trial;
   logic        unused_trial;

   assign busy      = (state_q != S_IDLE);
   assign endDiv    = end_q;
   assign divByZero = dbz_q;

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quot_q  <= '0;
         dvsr_q  <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         end_q   <= 1'b0;
         dbz_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quot_q  <= quot_d;
         dvsr_q  <= dvsr_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         end_q   <= end_d;
         dbz_q   <= dbz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (startDiv) state_d = (oper_B == '0) ? S_ZERO : S_RUN;
         S_RUN:  if (cnt_q == 5'd31) state_d = S_FIX;
         S_FIX:  state_d = S_IDLE;
         S_ZERO: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Trial subtract of the shifted partial remainder; bit 33 is the borrow.
   assign trial        = {1'b0, rem_q, quot_q[31]} - {2'b00, dvsr_q};
   assign unused_trial = trial[32];

   always_comb begin
      cnt_d  = cnt_q;
      rem_d  = rem_q;
      quot_d = quot_q;
      dvsr_d = dvsr_q;
      negq_d = negq_q;
      negr_d = negr_q;
      end_d  = 1'b0;
      dbz_d  = 1'b0;
      hi_d   = hi_q;
      lo_d   = lo_q;

      case (state_q)
         S_IDLE: begin
            if (startDiv) begin
               negq_d = divSigned & (oper_A[31] ^ oper_B[31]);
               negr_d = divSigned & oper_A[31];
               dvsr_d = (divSigned && oper_B[31]) ? -oper_B : oper_B;
               // ZERO reports the raw dividend, so it bypasses the magnitude step.
               if (oper_B == '0)                  quot_d = oper_A;
               else if (divSigned && oper_A[31])  quot_d = -oper_A;
               else                               quot_d = oper_A;
               rem_d  = '0;
               cnt_d  = '0;
            end
         end
         S_RUN: begin
            cnt_d = cnt_q + 5'd1;
            if (!trial[33]) begin
               rem_d  = trial[31:0];
               quot_d = {quot_q[30:0], 1'b1};
            end else begin
               rem_d  = {rem_q[30:0], quot_q[31]};
               quot_d = {quot_q[30:0], 1'b0};
            end
         end
         default: ;
      endcase

      if (state_q == S_FIX) begin
         hi_d  = negr_q ? -rem_q  : rem_q;
         lo_d  = negq_q ? -quot_q : quot_q;
         end_d = 1'b1;
      end else if (state_q == S_ZERO) begin
         hi_d  = quot_q;
         lo_d  = '1;
         end_d = 1'b1;
         dbz_d = 1'b1;
      end else if (endMult) begin
         hi_d = mul[63:32];
         lo_d = mul[31:0];
      end else begin
         if (mthi) hi_d = wdata;
         if (mtlo) lo_d = wdata;
      end
   end

`else

   logic unused_div_inputs;

   assign unused_div_inputs = ^{startDiv, divSigned, oper_A, oper_B};
   assign busy      = 1'b0;
   assign endDiv    = 1'b0;
   assign divByZero = 1'b0;

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (endMult) begin
         hi_d = mul[63:32];
         lo_d = mul[31:0];
      end else begin
         if (mthi) hi_d = wdata;
         if (mtlo) lo_d = wdata;
      end
   end

`endif

endmodule
